// File: rtl/addsub_acc_unit.sv
// Registered add/subtract stage with accumulator, optional signed
// saturation, carry/overflow/zero flags and a valid/ready handshake.
module addsub_acc_unit #(
    parameter int WIDTH    = 4,
    parameter bit SAT      = 1'b0,
    parameter int ACC_INIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             e,
    input  logic             s,
    input  logic             acc_sel,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [WIDTH-1:0] acc
);

    localparam logic [WIDTH-1:0] ACC_RST  = WIDTH'(ACC_INIT);
    localparam logic [WIDTH-1:0] SMIN     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] SMAX     = {1'b0, {(WIDTH-1){1'b1}}};

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             ovf_c;
    logic [WIDTH-1:0] y_c;
    logic             accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        op_a  = acc_sel ? acc : a;
        b_eff = s ? b : ~b;
        // subtract folds the +1 of two's complement into the carry-in
        sum   = {1'b0, op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, !s};
        ovf_c = (op_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                (sum[WIDTH-1] != op_a[WIDTH-1]);
        y_c   = sum[WIDTH-1:0];
        if (SAT && ovf_c)
            y_c = op_a[WIDTH-1] ? SMIN : SMAX;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            y         <= e ? y_c : '0;
            cout      <= e && sum[WIDTH];
            ovf       <= e && ovf_c;
            zero      <= e ? (y_c == '0) : 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // clear wins over an accumulate on the same edge
    always_ff @(posedge clk) begin
        if (rst || acc_clr)
            acc <= ACC_RST;
        else if (accept && e)
            acc <= y_c;
    end

endmodule

// File: tb/tb_addsub_acc_unit.sv
// Directed bench: a wrapping (SAT=0) and a saturating (SAT=1,
// ACC_INIT=3) instance share one stimulus stream.
module tb_addsub_acc_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       e;
    logic       s;
    logic       acc_sel;
    logic       acc_clr;
    logic       out_ready;

    logic       rdy0, ov0, co0, of0, z0;
    logic [3:0] y0, acc0;
    logic       rdy1, ov1, co1, of1, z1;
    logic [3:0] y1, acc1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    addsub_acc_unit #(.WIDTH(4), .SAT(1'b0), .ACC_INIT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
        .a(a), .b(b), .e(e), .s(s), .acc_sel(acc_sel),
        .acc_clr(acc_clr), .out_valid(ov0), .out_ready(out_ready),
        .y(y0), .cout(co0), .ovf(of0), .zero(z0), .acc(acc0)
    );

    addsub_acc_unit #(.WIDTH(4), .SAT(1'b1), .ACC_INIT(3)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .a(a), .b(b), .e(e), .s(s), .acc_sel(acc_sel),
        .acc_clr(acc_clr), .out_valid(ov1), .out_ready(out_ready),
        .y(y1), .cout(co1), .ovf(of1), .zero(z1), .acc(acc1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] ta, input logic [3:0] tb,
                        input logic te, input logic ts, input logic tsel);
        a = ta; b = tb; e = te; s = ts; acc_sel = tsel;
        in_valid = 1'b1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; e = 1'b0;
        s = 1'b0; acc_sel = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_ov0", ov0, 0);
        chk("rst_y0", y0, 0);
        chk("rst_z0", z0, 0);
        chk("rst_co0", co0, 0);
        chk("rst_of0", of0, 0);
        chk("rst_acc0", acc0, 0);
        chk("rst_acc1", acc1, 3);
        chk("rst_rdy0", rdy0, 1);

        // 5 + 6 overflows positive
        beat(4'b0101, 4'b0110, 1, 1, 0);
        tick();
        in_valid = 1'b0;
        chk("add_ov0", ov0, 1);
        chk("add_y0", y0, 4'b1011);
        chk("add_co0", co0, 0);
        chk("add_of0", of0, 1);
        chk("add_z0", z0, 0);
        chk("add_acc0", acc0, 4'b1011);
        chk("add_y1", y1, 4'b0111);
        chk("add_of1", of1, 1);
        chk("add_acc1", acc1, 4'b0111);

        // -8 - 4 overflows negative
        beat(4'b1000, 4'b0100, 1, 0, 0);
        tick();
        in_valid = 1'b0;
        chk("sub_y0", y0, 4'b0100);
        chk("sub_co0", co0, 1);
        chk("sub_of0", of0, 1);
        chk("sub_y1", y1, 4'b1000);
        chk("sub_co1", co1, 1);

        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        chk("clr_acc0", acc0, 0);
        chk("clr_acc1", acc1, 3);
        chk("clr_ov0", ov0, 0);

        beat(4'b0000, 4'b0010, 1, 1, 1);
        tick();
        chk("acc1_y0", y0, 2);
        chk("acc1_y1", y1, 5);
        tick();
        chk("acc2_y0", y0, 4);
        chk("acc2_y1", y1, 7);
        tick();
        chk("acc3_y0", y0, 6);
        chk("acc3_y1", y1, 7);
        chk("acc3_of1", of1, 1);
        chk("acc3_acc0", acc0, 6);

        e = 1'b0;
        tick();
        chk("dis_y0", y0, 0);
        chk("dis_z0", z0, 1);
        chk("dis_co0", co0, 0);
        chk("dis_ov0", ov0, 1);
        chk("dis_acc0", acc0, 6);
        chk("dis_acc1", acc1, 7);

        // clear beats a same-edge accumulate; y sees pre-clear acc
        beat(4'b0000, 4'b0001, 1, 1, 1);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        chk("pri_y0", y0, 7);
        chk("pri_y1", y1, 7);
        chk("pri_acc0", acc0, 0);
        chk("pri_acc1", acc1, 3);

        out_ready = 1'b0;
        beat(4'b0001, 4'b0001, 1, 1, 0);
        #1;
        chk("bp_rdy0", rdy0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_y0", y0, 7);
            chk("bp_ov0", ov0, 1);
            chk("bp_rdy0", rdy0, 0);
        end

        out_ready = 1'b1;
        #1;
        chk("bp_rel_rdy0", rdy0, 1);
        tick();
        chk("st0_y0", y0, 2);
        beat(4'b0010, 4'b0001, 1, 1, 0);
        tick();
        chk("st1_y0", y0, 3);
        chk("st1_ov0", ov0, 1);
        beat(4'b0011, 4'b0001, 1, 1, 0);
        tick();
        chk("st2_y0", y0, 4);
        in_valid = 1'b0;
        tick();
        chk("drain_ov0", ov0, 0);
        chk("drain_y0", y0, 4);

        out_ready = 1'b0;
        beat(4'b0001, 4'b0010, 1, 1, 0);
        tick();
        in_valid = 1'b0;
        chk("pend_ov0", ov0, 1);
        chk("pend_acc0", acc0, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_ov0", ov0, 0);
        chk("mrst_ov1", ov1, 0);
        chk("mrst_acc0", acc0, 0);
        chk("mrst_acc1", acc1, 3);
        chk("mrst_rdy0", rdy0, 1);
        chk("mrst_rdy1", rdy1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/addsub_acc_unit.md
Name: addsub_acc_unit

Overview:
- Parametrised, registered add/subtract unit with enable (E) and operation select (S), plus carry, overflow and zero flags.
- Has an internal accumulator, optional signed saturation, and a valid/ready handshake on input and output.
- Generalises the team's 4-bit combinational A/B/E/S add-subtract block into a pipelined, stallable datapath stage.
- Sits between the operand source and the result consumer in the arithmetic datapath.

Parameters:
- WIDTH, 4: operand, result and accumulator width in bits (legal range 2..32).
- SAT, 0: 1 = on signed overflow, clamp the result to signed max/min; 0 = wrap.
- ACC_INIT, 0: value loaded into the accumulator on reset and on acc_clr.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept an operand beat.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- e  in  1  enable; 0 = beat produces a zero result and does not touch the accumulator.
- s  in  1  operation; 1 = add, 0 = subtract (first operand minus b).
- acc_sel  in  1  1 = first operand is the accumulator, 0 = first operand is a.
- acc_clr  in  1  load the accumulator with ACC_INIT (independent of the handshake).
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  consumer accepts the result.
- y  out  WIDTH  result.
- cout  out  1  carry out; for subtract, 1 = no borrow.
- ovf  out  1  signed overflow of the unsaturated operation.
- zero  out  1  y == 0.
- acc  out  WIDTH  current accumulator value.

Behaviour:
- Reset: out_valid=0, y=0, cout=0, ovf=0, zero=0, acc=ACC_INIT. in_ready=1 in the first cycle after reset.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - An input beat is accepted when in_valid && in_ready. An output beat is consumed when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, y/flags hold stable and no input is accepted.
- Latency: the result appears in the cycle after acceptance (1 cycle). Throughput is 1 beat/cycle when out_ready is held high.
- out_valid: set on accept; cleared on consume without a same-cycle accept; stays 1 on simultaneous consume+accept.
- Arithmetic:
  - opA = acc_sel ? acc : a.
  - Add: sum = opA + b. Subtract: sum = opA + ~b + 1. Both are computed WIDTH+1 bits wide; cout = sum[WIDTH].
  - ovf = (opA[msb] == b_eff[msb]) && (sum[msb] != opA[msb]), where b_eff = s ? b : ~b.
  - SAT=1 and ovf=1: y = opA[msb] ? 1 followed by zeros (signed min) : 0 followed by ones (signed max).
  - Otherwise y = sum[WIDTH-1:0].
  - zero is computed on the final y.
- Enable:
  - Accepted beat with e=0: y=0, cout=0, ovf=0, zero=1, out_valid=1, accumulator unchanged.
  - Accepted beat with e=1: acc <= final y (including saturation) in the same edge that registers y.
- acc_clr:
  - acc_clr=1 loads ACC_INIT and has priority over the accumulator update from a simultaneous accept.
  - That beat's y still uses the pre-clear acc if acc_sel=1.
  - acc_clr does not affect out_valid or y.
- Reset mid-operation: any pending result is discarded (out_valid=0) and acc returns to ACC_INIT on the same edge.
- No state machine beyond out_valid. All outputs are registered except in_ready.

Test Plan:
- WIDTH=4, SAT=0, a=0101, b=0110, e=1, s=1, acc_sel=0 -> next cycle y=1011, cout=0, ovf=1, zero=0, acc=1011.
- Same operands with SAT=1 -> y=0111, ovf=1, acc=0111.
- a=1000, b=0100, e=1, s=0 -> y=0100, cout=1, ovf=1 (SAT=0); with SAT=1 -> y=1000.
- Accumulate: acc_clr pulse, then 3 beats acc_sel=1, s=1, b=0010 -> y = 0010, 0100, 0110; then e=0 beat -> y=0000, zero=1, acc stays 0110.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and y stable. Then raise out_ready -> one beat per cycle, no beat lost or duplicated.
- Reset asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, acc=ACC_INIT, in_ready=1.
